// File: rtl/detection_result_queue.sv
// detection_result_queue
//
// First-word-fall-through FIFO for window detections coming out of the core
// result arbiter. Each entry is {x, y, scale}. The oldest entry sits in an
// output register that drives pop_*; the remaining entries live in a
// DEPTH-entry memory. Valid/ready handshake on both sides.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   flush                   synchronous clear; wins over push/pop that cycle
//   push_valid/push_ready   producer handshake; push_x/push_y/push_scale data
//   pop_valid/pop_ready     consumer handshake; pop_x/pop_y/pop_scale data
//   count, full, empty      registered occupancy status (includes output reg)
//   total_hits              accepted pushes since reset/flush, saturating
module detection_result_queue #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned X_BITS     = 9,
    parameter int unsigned Y_BITS     = 8,
    parameter int unsigned SCALE_BITS = 8,
    parameter int unsigned COUNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push_valid,
    input  logic [X_BITS-1:0]     push_x,
    input  logic [Y_BITS-1:0]     push_y,
    input  logic [SCALE_BITS-1:0] push_scale,
    output logic                  push_ready,
    output logic                  pop_valid,
    output logic [X_BITS-1:0]     pop_x,
    output logic [Y_BITS-1:0]     pop_y,
    output logic [SCALE_BITS-1:0] pop_scale,
    input  logic                  pop_ready,
    output logic [COUNT_BITS-1:0] count,
    output logic                  full,
    output logic                  empty,
    output logic [31:0]           total_hits
);

    localparam int unsigned PtrBits   = $clog2(DEPTH);
    localparam int unsigned EntryBits = X_BITS + Y_BITS + SCALE_BITS;

    logic [EntryBits-1:0]  mem [DEPTH];
    logic [PtrBits-1:0]    wr_ptr_q, rd_ptr_q;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic                  full_q, empty_q;
    logic                  out_valid_q;
    logic [EntryBits-1:0]  out_data_q;
    logic [31:0]           total_hits_q;

    logic                  do_push, do_pop, mem_empty, out_free;
    logic                  out_load_mem, out_bypass, mem_write;
    logic [EntryBits-1:0]  push_data;

    assign push_data  = {push_x, push_y, push_scale};
    assign push_ready = (count_q != COUNT_BITS'(DEPTH));
    assign do_push    = push_valid && push_ready;
    assign do_pop     = out_valid_q && pop_ready;

    // Memory occupancy is the total count minus the entry in the output register.
    assign mem_empty    = (count_q == COUNT_BITS'(out_valid_q));
    assign out_free     = !out_valid_q || do_pop;
    assign out_load_mem = out_free && !mem_empty;
    // Bypass only when nothing older is waiting in memory, preserving order.
    assign out_bypass   = out_free && mem_empty && do_push;
    assign mem_write    = do_push && !out_bypass;

    assign count_d = count_q + COUNT_BITS'(do_push) - COUNT_BITS'(do_pop);

    // Storage array is not reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (mem_write && !flush) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            total_hits_q <= '0;
        end else if (flush) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            out_valid_q  <= 1'b0;
            total_hits_q <= '0;
        end else begin
            if (mem_write) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (out_load_mem) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                out_data_q  <= mem[rd_ptr_q];
                out_valid_q <= 1'b1;
            end else if (out_bypass) begin
                out_data_q  <= push_data;
                out_valid_q <= 1'b1;
            end else if (do_pop) begin
                out_valid_q <= 1'b0;
            end
            count_q <= count_d;
            full_q  <= (count_d == COUNT_BITS'(DEPTH));
            empty_q <= (count_d == '0);
            if (do_push && (total_hits_q != 32'hFFFF_FFFF)) begin
                total_hits_q <= total_hits_q + 32'd1;
            end
        end
    end

    assign pop_valid                   = out_valid_q;
    assign {pop_x, pop_y, pop_scale}   = out_data_q;
    assign count                       = count_q;
    assign full                        = full_q;
    assign empty                       = empty_q;
    assign total_hits                  = total_hits_q;

endmodule

// File: tb/tb_detection_result_queue.sv
module tb_detection_result_queue;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        push_valid = 1'b0;
    logic [8:0]  push_x = '0;
    logic [7:0]  push_y = '0;
    logic [7:0]  push_scale = '0;
    logic        push_ready;
    logic        pop_valid;
    logic [8:0]  pop_x;
    logic [7:0]  pop_y;
    logic [7:0]  pop_scale;
    logic        pop_ready = 1'b0;
    logic [8:0]  count;
    logic        full;
    logic        empty;
    logic [31:0] total_hits;

    int vectors = 0;
    int miscompares = 0;

    detection_result_queue dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .push_valid (push_valid),
        .push_x     (push_x),
        .push_y     (push_y),
        .push_scale (push_scale),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_x      (pop_x),
        .pop_y      (pop_y),
        .pop_scale  (pop_scale),
        .pop_ready  (pop_ready),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .total_hits (total_hits)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] entry(int i);
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] s;
        x = 9'(i * 5 + 1);
        y = 8'(255 - i);
        s = 8'(i * 7);
        return {x, y, s};
    endfunction

    function automatic logic [24:0] pop_data();
        return {pop_x, pop_y, pop_scale};
    endfunction

    // Advance one edge and settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [24:0] d);
        push_valid = v;
        {push_x, push_y, push_scale} = d;
    endtask

    task automatic pulse_reset();
        drive(1'b0, '0);
        pop_ready = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if (push_ready !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || count !== 9'd0 ||
            pop_valid !== 1'b0 || total_hits !== 32'd0) begin
            miscompares++;
            $display("FAIL %s: got rdy=%b empty=%b full=%b count=%0d pv=%b hits=%0d, want 1 1 0 0 0 0",
                     name, push_ready, empty, full, count, pop_valid, total_hits);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        vectors++;
        if (pop_data() !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", pop_data());
        end
        check_idle("reset_in");
        reset_n = 1'b1;
        step();
        step();
        check_idle("reset_idle");
    endtask

    task automatic test_single();
        pulse_reset();
        pop_ready = 1'b0;
        drive(1'b1, {9'd12, 8'd34, 8'd5});
        step();
        drive(1'b0, '0);
        vectors++;
        if (pop_valid !== 1'b1 || pop_x !== 9'd12 || pop_y !== 8'd34 || pop_scale !== 8'd5 ||
            count !== 9'd1 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL single_push: got pv=%b %0d/%0d/%0d count=%0d, want 1 12/34/5 1",
                     pop_valid, pop_x, pop_y, pop_scale, count);
        end
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
        vectors++;
        if (empty !== 1'b1 || pop_valid !== 1'b0 || count !== 9'd0 || total_hits !== 32'd1) begin
            miscompares++;
            $display("FAIL single_pop: got empty=%b pv=%b count=%0d hits=%0d, want 1 0 0 1",
                     empty, pop_valid, count, total_hits);
        end
    endtask

    task automatic test_fill_overflow();
        pulse_reset();
        pop_ready = 1'b0;
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, entry(i));
            step();
        end
        drive(1'b0, '0);
        vectors++;
        if (count !== 9'd256 || full !== 1'b1 || push_ready !== 1'b0 || total_hits !== 32'd256) begin
            miscompares++;
            $display("FAIL fill_status: got count=%0d full=%b rdy=%b hits=%0d, want 256 1 0 256",
                     count, full, push_ready, total_hits);
        end
        // Push and pop together while full: the push must be rejected.
        drive(1'b1, entry(900));
        pop_ready = 1'b1;
        vectors++;
        if (pop_valid !== 1'b1 || pop_data() !== entry(0)) begin
            miscompares++;
            $display("FAIL full_pop_head: got pv=%b %h want 1 %h", pop_valid, pop_data(), entry(0));
        end
        step();
        drive(1'b0, '0);
        vectors++;
        if (count !== 9'd255 || full !== 1'b0 || total_hits !== 32'd256) begin
            miscompares++;
            $display("FAIL full_push_pop: got count=%0d full=%b hits=%0d, want 255 0 256",
                     count, full, total_hits);
        end
        for (int k = 1; k < 256; k++) begin
            vectors++;
            if (pop_valid !== 1'b1 || pop_data() !== entry(k)) begin
                miscompares++;
                $display("FAIL drain_%0d: got pv=%b %h want 1 %h", k, pop_valid, pop_data(), entry(k));
            end
            step();
        end
        pop_ready = 1'b0;
        vectors++;
        if (empty !== 1'b1 || pop_valid !== 1'b0 || count !== 9'd0) begin
            miscompares++;
            $display("FAIL drain_empty: got empty=%b pv=%b count=%0d, want 1 0 0",
                     empty, pop_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [24:0] sb[$];
        logic [24:0] exp_d;
        int j;
        int received;
        int cycles;
        pulse_reset();
        j = 0;
        received = 0;
        cycles = 0;
        pop_ready = 1'b1;
        while ((j < 1000 || sb.size() > 0) && cycles < 1100) begin
            drive(j < 1000, entry(j + 3));
            if (pop_valid) begin
                exp_d = (sb.size() > 0) ? sb.pop_front() : 25'h1FFFFFF;
                received++;
                vectors++;
                if (pop_data() !== exp_d) begin
                    miscompares++;
                    $display("FAIL stream_order_%0d: got %h want %h", received, pop_data(), exp_d);
                end
            end
            vectors++;
            if (count > 9'd2) begin
                miscompares++;
                $display("FAIL stream_count: got %0d want <=2", count);
            end
            if (push_valid && push_ready) begin
                sb.push_back(entry(j + 3));
                j++;
            end
            step();
            cycles++;
        end
        drive(1'b0, '0);
        pop_ready = 1'b0;
        vectors++;
        if (received !== 1000 || total_hits !== 32'd1000 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_total: got rx=%0d hits=%0d empty=%b, want 1000 1000 1",
                     received, total_hits, empty);
        end
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        drive(1'b1, entry(40));
        step();
        drive(1'b1, entry(41));
        pop_ready = 1'b1;
        vectors++;
        if (pop_data() !== entry(40) || count !== 9'd1) begin
            miscompares++;
            $display("FAIL simul_pre: got %h count=%0d want %h 1", pop_data(), count, entry(40));
        end
        step();
        drive(1'b0, '0);
        pop_ready = 1'b0;
        vectors++;
        if (pop_valid !== 1'b1 || pop_data() !== entry(41) || count !== 9'd1 ||
            total_hits !== 32'd2) begin
            miscompares++;
            $display("FAIL simul_post: got pv=%b %h count=%0d hits=%0d, want 1 %h 1 2",
                     pop_valid, pop_data(), count, total_hits, entry(41));
        end
    endtask

    task automatic test_flush();
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, entry(i + 60));
            step();
        end
        drive(1'b1, entry(99));
        flush = 1'b1;
        vectors++;
        if (count !== 9'd10 || push_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_pre: got count=%0d rdy=%b want 10 1", count, push_ready);
        end
        step();
        flush = 1'b0;
        drive(1'b0, '0);
        check_idle("flush_post");
        step();
        check_idle("flush_settled");
    endtask

    task automatic test_async_reset();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, entry(i + 200));
            step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (pop_data() !== 25'd0) begin
            miscompares++;
            $display("FAIL areset_data: got %h want 0", pop_data());
        end
        check_idle("areset_now");
        drive(1'b0, '0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_idle("areset_after");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_simultaneous();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
